// File: rtl/mem_to_axi_if.sv
// AXI4 bus bundle connecting a master to a slave.
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH.
// Modports: Master (drives AW/W/AR valid + payload, B/R ready), Slave (mirror).
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem_to_axi.sv
// Single-outstanding bridge: each granted memory request becomes one
// single-beat AXI4 read (AR/R) or write (AW/W/B); completion pulses mem_rvalid_o.
// Ports: clk, rst_n (async, active-low); mem_req_i/mem_gnt_o (comb grant),
// mem_we_i, mem_addr_i, mem_wdata_i, mem_strb_i; mem_rvalid_o, mem_rdata_o;
// axi (AXI_BUS.Master).
// Optional: define MEM_TO_AXI_ERR_EN to add err_o, err_addr_o, err_clr_i
// (sticky capture of the first SLVERR/DECERR response).
module mem_to_axi #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_req_i,
    output logic                        mem_gnt_o,
    input  logic                        mem_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] mem_strb_i,
    output logic                        mem_rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_rdata_o,
    AXI_BUS.Master                      axi
`ifdef MEM_TO_AXI_ERR_EN
   ,output logic                        err_o,
    output logic [AXI_ADDR_WIDTH-1:0]   err_addr_o,
    input  logic                        err_clr_i
`endif
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_e;

    state_e                    state_q, state_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      b_ready_q, b_ready_d;
    logic                      r_ready_q, r_ready_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]         strb_q, strb_d;

    // Next-state, handshake bookkeeping and combinational grant
    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        b_ready_d  = b_ready_q;
        r_ready_d  = r_ready_q;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        mem_gnt_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_gnt_o = mem_req_i;
                if (mem_req_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    strb_d  = mem_strb_i;
                    if (mem_we_i) begin
                        state_d    = WR_ADDR_DATA;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both are done
                if (axi.aw_ready) aw_valid_d = 1'b0;
                if (axi.w_ready)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (axi.b_valid) begin
                    state_d   = IDLE;
                    b_ready_d = 1'b0;
                    rvalid_d  = 1'b1;
                end
            end
            RD_ADDR: begin
                if (axi.ar_ready) begin
                    state_d    = RD_DATA;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (axi.r_valid) begin
                    state_d   = IDLE;
                    r_ready_d = 1'b0;
                    rdata_d   = axi.r_data;
                    rvalid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            b_ready_q  <= b_ready_d;
            r_ready_q  <= r_ready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
        end
    end

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;

    // Single-beat INCR, full-width bursts; address passed through unaligned
    assign axi.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.aw_addr   = addr_q;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = 3'(SIZE);
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_qos    = 4'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_atop   = 6'd0;
    assign axi.aw_user   = '0;
    assign axi.aw_valid  = aw_valid_q;

    assign axi.w_data    = wdata_q;
    assign axi.w_strb    = strb_q;
    assign axi.w_last    = 1'b1;
    assign axi.w_user    = '0;
    assign axi.w_valid   = w_valid_q;

    assign axi.b_ready   = b_ready_q;

    assign axi.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = 3'(SIZE);
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_qos    = 4'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = '0;
    assign axi.ar_valid  = ar_valid_q;

    assign axi.r_ready   = r_ready_q;

`ifdef MEM_TO_AXI_ERR_EN
    logic                      err_q;
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
    logic                      err_hit;

    // resp[1] set means SLVERR or DECERR on the completing beat
    assign err_hit = (state_q == WR_RESP && axi.b_valid && axi.b_resp[1]) ||
                     (state_q == RD_DATA && axi.r_valid && axi.r_resp[1]);

    // First error sticks; a clear coinciding with a new error keeps the new one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (err_hit && (!err_q || err_clr_i)) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
        end else if (err_clr_i) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
`endif
endmodule

// File: tb/tb_mem_to_axi.sv
module tb_mem_to_axi;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 4;
    localparam int unsigned UW  = 1;
    localparam int unsigned AID = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_req_i = 1'b0;
    logic mem_gnt_o;
    logic mem_we_i = 1'b0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic [7:0] mem_strb_i = '0;
    logic mem_rvalid_o;
    logic [DW-1:0] mem_rdata_o;
`ifdef MEM_TO_AXI_ERR_EN
    logic err_o;
    logic [AW-1:0] err_addr_o;
    logic err_clr_i = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi();

    mem_to_axi #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                 .AXI_USER_WIDTH(UW), .AXI_ID(AID)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_strb_i(mem_strb_i), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
        .axi(axi)
`ifdef MEM_TO_AXI_ERR_EN
       ,.err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AXI slave RAM model with configurable stalls ----------------
    int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait, w_wait, ar_wait, r_cnt;
    logic [63:0] smem [256];
    logic have_aw, have_w, s_b_valid, s_r_valid, r_pend;
    logic [1:0] s_b_resp, s_r_resp;
    logic [63:0] s_r_data, r_addr;
    logic [63:0] cap_aw_addr, cap_ar_addr, cap_w_data;
    logic [7:0]  cap_w_strb, cap_aw_len, cap_ar_len;
    logic [2:0]  cap_aw_size, cap_ar_size;
    logic [1:0]  cap_aw_burst, cap_ar_burst;
    logic [IW-1:0] cap_aw_id, cap_ar_id;
    logic cap_w_last;
    int aw_beats, w_beats, ar_beats, b_hs_cyc, stab_err;
    logic aw_stalled, w_stalled, ar_stalled;
    logic [63:0] aw_prev, w_prev, ar_prev;

    assign axi.aw_ready = axi.aw_valid && (aw_wait >= aw_delay);
    assign axi.w_ready  = axi.w_valid  && (w_wait  >= w_delay);
    assign axi.ar_ready = axi.ar_valid && (ar_wait >= ar_delay);
    assign axi.b_valid  = s_b_valid;
    assign axi.b_resp   = s_b_resp;
    assign axi.b_id     = IW'(AID);
    assign axi.b_user   = '0;
    assign axi.r_valid  = s_r_valid;
    assign axi.r_data   = s_r_data;
    assign axi.r_resp   = s_r_resp;
    assign axi.r_id     = IW'(AID);
    assign axi.r_last   = 1'b1;
    assign axi.r_user   = '0;

    logic aw_hs, w_hs, ar_hs, got_aw, got_w;
    logic [63:0] wa, wd, wr_word;
    logic [7:0] ws;
    always_comb begin
        aw_hs  = axi.aw_valid && axi.aw_ready;
        w_hs   = axi.w_valid && axi.w_ready;
        ar_hs  = axi.ar_valid && axi.ar_ready;
        got_aw = have_aw || aw_hs;
        got_w  = have_w || w_hs;
        wa = aw_hs ? axi.aw_addr : cap_aw_addr;
        wd = w_hs ? axi.w_data : cap_w_data;
        ws = w_hs ? axi.w_strb : cap_w_strb;
        wr_word = smem[wa[10:3]];
        for (int b = 0; b < 8; b++) if (ws[b]) wr_word[8*b +: 8] = wd[8*b +: 8];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) smem[i] <= '0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
            have_aw <= 1'b0; have_w <= 1'b0; s_b_valid <= 1'b0; s_r_valid <= 1'b0; r_pend <= 1'b0;
            s_b_resp <= 2'b00; s_r_resp <= 2'b00; s_r_data <= '0; r_addr <= '0;
            aw_stalled <= 1'b0; w_stalled <= 1'b0; ar_stalled <= 1'b0;
        end else begin
            // AW channel
            if (aw_hs) begin
                cap_aw_addr <= axi.aw_addr; cap_aw_len <= axi.aw_len; cap_aw_size <= axi.aw_size;
                cap_aw_burst <= axi.aw_burst; cap_aw_id <= axi.aw_id;
                aw_beats <= aw_beats + 1; aw_wait <= 0; aw_stalled <= 1'b0;
            end else if (axi.aw_valid) begin
                if (aw_stalled && axi.aw_addr !== aw_prev) stab_err <= stab_err + 1;
                aw_stalled <= 1'b1; aw_prev <= axi.aw_addr; aw_wait <= aw_wait + 1;
            end else begin
                if (aw_stalled) stab_err <= stab_err + 1;
                aw_stalled <= 1'b0;
            end
            // W channel
            if (w_hs) begin
                cap_w_data <= axi.w_data; cap_w_strb <= axi.w_strb; cap_w_last <= axi.w_last;
                w_beats <= w_beats + 1; w_wait <= 0; w_stalled <= 1'b0;
            end else if (axi.w_valid) begin
                if (w_stalled && axi.w_data !== w_prev) stab_err <= stab_err + 1;
                w_stalled <= 1'b1; w_prev <= axi.w_data; w_wait <= w_wait + 1;
            end else begin
                if (w_stalled) stab_err <= stab_err + 1;
                w_stalled <= 1'b0;
            end
            // Write commit and B
            if (got_aw && got_w && !s_b_valid) begin
                smem[wa[10:3]] <= wr_word;
                s_b_valid <= 1'b1;
                s_b_resp <= (wa >= 64'h8000_0000) ? 2'b11 : 2'b00;
                have_aw <= 1'b0; have_w <= 1'b0;
            end else begin
                have_aw <= got_aw; have_w <= got_w;
            end
            if (s_b_valid && axi.b_ready) begin
                s_b_valid <= 1'b0; b_hs_cyc <= cyc;
            end
            // AR channel and R
            if (ar_hs) begin
                cap_ar_addr <= axi.ar_addr; cap_ar_len <= axi.ar_len; cap_ar_size <= axi.ar_size;
                cap_ar_burst <= axi.ar_burst; cap_ar_id <= axi.ar_id;
                ar_beats <= ar_beats + 1; ar_wait <= 0; ar_stalled <= 1'b0;
                s_r_resp <= (axi.ar_addr >= 64'h8000_0000) ? 2'b11 : 2'b00;
                if (r_delay == 0) begin
                    s_r_valid <= 1'b1; s_r_data <= smem[axi.ar_addr[10:3]];
                end else begin
                    r_pend <= 1'b1; r_cnt <= r_delay - 1; r_addr <= axi.ar_addr;
                end
            end else if (axi.ar_valid) begin
                if (ar_stalled && axi.ar_addr !== ar_prev) stab_err <= stab_err + 1;
                ar_stalled <= 1'b1; ar_prev <= axi.ar_addr; ar_wait <= ar_wait + 1;
            end else begin
                if (ar_stalled) stab_err <= stab_err + 1;
                ar_stalled <= 1'b0;
            end
            if (r_pend) begin
                if (r_cnt == 0) begin
                    r_pend <= 1'b0; s_r_valid <= 1'b1; s_r_data <= smem[r_addr[10:3]];
                end else r_cnt <= r_cnt - 1;
            end
            if (s_r_valid && axi.r_ready) s_r_valid <= 1'b0;
        end
    end

    initial begin
        aw_beats = 0; w_beats = 0; ar_beats = 0; b_hs_cyc = -1; stab_err = 0;
    end

    // Completion monitor
    logic [63:0] rv_q[$];
    int rv_c[$];
    always @(negedge clk) if (mem_rvalid_o === 1'b1) begin
        rv_q.push_back(mem_rdata_o);
        rv_c.push_back(cyc);
    end

    // ---------------- Byte-addressed reference memory ----------------
    logic [7:0] ref_mem [longint unsigned];

    function automatic void ref_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) if (s[b]) ref_mem[a + 64'(b)] = d[8*b +: 8];
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] v = '0;
        for (int b = 0; b < 8; b++)
            if (ref_mem.exists(a + 64'(b))) v[8*b +: 8] = ref_mem[a + 64'(b)];
        return v;
    endfunction

    // One complete memory-side transaction; returns data and grant/done cycles
    task automatic mem_op(input bit we, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, output logic [63:0] rd, output int gc, output int dc);
        int n = 0;
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_wdata_i = d; mem_strb_i = s;
        #1;
        while (mem_gnt_o !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if (mem_gnt_o !== 1'b1) begin errors++; $display("FAIL grant_timeout: gnt=%b expected 1", mem_gnt_o); end
        gc = cyc;
        @(posedge clk); #1;
        mem_req_i = 1'b0;
        n = 0;
        while (rv_q.size() == 0 && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (rv_q.size() == 0) begin
            errors++; $display("FAIL completion_timeout: no rvalid for addr %h", a);
            rd = 'x; dc = -1;
        end else begin
            rd = rv_q.pop_front(); dc = rv_c.pop_front();
        end
        if (we) ref_write(a, d, s);
    endtask

    task automatic set_delays(input int a, input int w, input int ar, input int r);
        aw_delay = a; w_delay = w; ar_delay = ar; r_delay = r;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_ctrl: got %b expected 00000",
                {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}); end
        checks++; if (mem_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", mem_rvalid_o); end
        checks++; if (mem_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata_o); end
        checks++; if (axi.aw_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", axi.aw_addr); end
`ifdef MEM_TO_AXI_ERR_EN
        checks++; if (err_o !== 1'b0 || err_addr_o !== 64'h0) begin errors++;
            $display("FAIL reset_err: got %b/%h expected 0/0", err_o, err_addr_o); end
`endif
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (mem_gnt_o !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b expected 0", mem_gnt_o); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; int gc, dc;
        set_delays(0, 0, 0, 0);
        mem_op(1'b1, 64'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, rd, gc, dc);
        checks++; if (dc - gc !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", dc - gc); end
        checks++; if ({cap_aw_addr, cap_aw_len, cap_aw_size, cap_aw_burst, cap_aw_id} !==
                      {64'h100, 8'd0, 3'd3, 2'b01, IW'(AID)}) begin errors++;
            $display("FAIL aw_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d expected 100/0/3/1/%0d",
                cap_aw_addr, cap_aw_len, cap_aw_size, cap_aw_burst, cap_aw_id, AID); end
        checks++; if ({cap_w_data, cap_w_strb, cap_w_last} !== {64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1}) begin errors++;
            $display("FAIL w_fields: got %h/%h/%b expected deadbeefcafef00d/ff/1", cap_w_data, cap_w_strb, cap_w_last); end
        mem_op(1'b0, 64'h100, 64'h0, 8'h00, rd, gc, dc);
        checks++; if (rd !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL read_back: got %h expected deadbeefcafef00d", rd); end
        checks++; if (dc - gc !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", dc - gc); end
        checks++; if ({cap_ar_addr, cap_ar_len, cap_ar_size, cap_ar_burst, cap_ar_id} !==
                      {64'h100, 8'd0, 3'd3, 2'b01, IW'(AID)}) begin errors++;
            $display("FAIL ar_fields: got addr=%h len=%0d size=%0d expected 100/0/3", cap_ar_addr, cap_ar_len, cap_ar_size); end
        repeat (4) @(negedge clk);
        checks++; if (rv_q.size() !== 0) begin errors++; $display("FAIL extra_rvalid: got %0d pulses expected 0", rv_q.size()); end
    endtask

    task automatic test_partial_strobe();
        logic [63:0] rd, prev; int gc, dc;
        mem_op(1'b1, 64'h200, 64'h11111111_11111111, 8'hFF, rd, gc, dc);
        mem_op(1'b1, 64'h200, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, rd, gc, dc);
        mem_op(1'b0, 64'h200, 64'h0, 8'h0, rd, gc, dc);
        checks++; if (rd !== 64'h11111111_FFFFFFFF) begin errors++; $display("FAIL partial_strb: got %h expected 11111111ffffffff", rd); end
        checks++; if (rd !== ref_read(64'h200)) begin errors++; $display("FAIL partial_model: got %h expected %h", rd, ref_read(64'h200)); end
        prev = rd;
        mem_op(1'b1, 64'h208, 64'h0123456789ABCDEF, 8'hFF, rd, gc, dc);
        #1;
        checks++; if (mem_rdata_o !== prev) begin errors++; $display("FAIL rdata_hold: got %h expected %h", mem_rdata_o, prev); end
    endtask

    task automatic test_skew();
        logic [63:0] rd, d; int gc, dc, awb, wb;
        for (int k = 0; k < 2; k++) begin
            set_delays(k == 0 ? 3 : 0, k == 0 ? 0 : 3, 0, 0);
            awb = aw_beats; wb = w_beats;
            d = {$urandom, $urandom};
            mem_op(1'b1, 64'h300 + 64'(8 * k), d, 8'hFF, rd, gc, dc);
            checks++; if (aw_beats - awb !== 1 || w_beats - wb !== 1) begin errors++;
                $display("FAIL skew%0d_beats: got aw=%0d w=%0d expected 1/1", k, aw_beats - awb, w_beats - wb); end
            checks++; if (dc !== b_hs_cyc + 1) begin errors++; $display("FAIL skew%0d_b_to_rvalid: got %0d expected %0d", k, dc, b_hs_cyc + 1); end
            checks++; if (dc - gc !== 6) begin errors++; $display("FAIL skew%0d_latency: got %0d expected 6", k, dc - gc); end
            set_delays(0, 0, 0, 0);
            mem_op(1'b0, 64'h300 + 64'(8 * k), 64'h0, 8'h0, rd, gc, dc);
            checks++; if (rd !== d) begin errors++; $display("FAIL skew%0d_data: got %h expected %h", k, rd, d); end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL payload_stable: got %0d violations expected 0", stab_err); end
    endtask

    task automatic test_back_to_back();
        int gcs[8]; logic [63:0] exp_rd[8]; int i = 0, n = 0;
        logic [63:0] d;
        set_delays(0, 0, 0, 0);
        rv_q.delete(); rv_c.delete();
        @(negedge clk);
        d = {$urandom, $urandom};
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 64'h400; mem_wdata_i = d; mem_strb_i = 8'hFF;
        while (i < 8 && n < 100) begin
            #1;
            if (mem_gnt_o === 1'b1) begin
                gcs[i] = cyc;
                if (mem_we_i) ref_write(mem_addr_i, mem_wdata_i, mem_strb_i);
                else exp_rd[i] = ref_read(mem_addr_i);
                i++;
                @(posedge clk); #1;
                if (i < 8) begin
                    mem_we_i = (i % 2 == 0);
                    mem_addr_i = 64'h400 + 64'(8 * (i / 2));
                    mem_wdata_i = {$urandom, $urandom};
                end else mem_req_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        mem_req_i = 1'b0;
        checks++; if (i !== 8) begin errors++; $display("FAIL b2b_grants: got %0d expected 8", i); end
        for (int k = 1; k < i; k++) begin
            checks++; if (gcs[k] - gcs[k-1] !== 3) begin errors++;
                $display("FAIL b2b_spacing%0d: got %0d expected 3", k, gcs[k] - gcs[k-1]); end
        end
        n = 0;
        while (rv_q.size() < i && n < 50) begin @(negedge clk); n++; end
        checks++; if (rv_q.size() !== 8) begin errors++; $display("FAIL b2b_rvalid_count: got %0d expected 8", rv_q.size()); end
        for (int k = 0; k < 8 && rv_q.size() > 0; k++) begin
            logic [63:0] r = rv_q.pop_front(); int c = rv_c.pop_front();
            checks++; if (c !== gcs[k] + 3) begin errors++; $display("FAIL b2b_done%0d: got %0d expected %0d", k, c, gcs[k] + 3); end
            if (k % 2 == 1) begin
                checks++; if (r !== exp_rd[k]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, r, exp_rd[k]); end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, a, d, e; logic [7:0] s; bit we; int gc, dc;
        for (int k = 0; k < 30; k++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            a = 64'($urandom_range(0, 255)) * 64'd8;
            d = {$urandom, $urandom};
            s = 8'($urandom);
            e = ref_read(a);
            mem_op(we, a, d, s, rd, gc, dc);
            if (!we) begin
                checks++; if (rd !== e) begin errors++; $display("FAIL rand%0d_data: addr %h got %h expected %h", k, a, rd, e); end
            end
        end
        set_delays(0, 0, 0, 0);
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand_stable: got %0d violations expected 0", stab_err); end
    endtask

    task automatic test_error_resp();
        logic [63:0] rd; int gc, dc;
        mem_op(1'b0, 64'h8000_0000, 64'h0, 8'h0, rd, gc, dc);
        checks++; if (dc - gc !== 3) begin errors++; $display("FAIL decerr_complete: got %0d expected 3", dc - gc); end
`ifdef MEM_TO_AXI_ERR_EN
        checks++; if (err_o !== 1'b1 || err_addr_o !== 64'h8000_0000) begin errors++;
            $display("FAIL err_capture: got %b/%h expected 1/80000000", err_o, err_addr_o); end
        mem_op(1'b0, 64'h9000_0000, 64'h0, 8'h0, rd, gc, dc);
        checks++; if (err_o !== 1'b1 || err_addr_o !== 64'h8000_0000) begin errors++;
            $display("FAIL err_sticky: got %b/%h expected 1/80000000", err_o, err_addr_o); end
        @(negedge clk); err_clr_i = 1'b1;
        @(negedge clk); err_clr_i = 1'b0; #1;
        checks++; if (err_o !== 1'b0 || err_addr_o !== 64'h0) begin errors++;
            $display("FAIL err_clear: got %b/%h expected 0/0", err_o, err_addr_o); end
`endif
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] rd; int n = 0;
        set_delays(0, 0, 0, 10);
        rv_q.delete(); rv_c.delete();
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h100;
        @(posedge clk); #1;
        mem_req_i = 1'b0;
        while (axi.r_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (axi.r_ready !== 1'b1) begin errors++; $display("FAIL mid_read_reach: r_ready=%b expected 1", axi.r_ready); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({axi.r_ready, axi.ar_valid, mem_rvalid_o} !== 3'b000) begin errors++;
            $display("FAIL mid_read_reset: got %b expected 000", {axi.r_ready, axi.ar_valid, mem_rvalid_o}); end
        ref_mem.delete();
        @(negedge clk); rst_n = 1'b1; set_delays(0, 0, 0, 0);
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 64'h100; #1;
        checks++; if (mem_gnt_o !== 1'b1) begin errors++; $display("FAIL post_reset_gnt: got %b expected 1", mem_gnt_o); end
        @(posedge clk); #1; mem_req_i = 1'b0;
        n = 0;
        while (rv_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rv_q.size() !== 1) begin errors++; $display("FAIL post_reset_rvalid: got %0d expected 1", rv_q.size()); end
        if (rv_q.size() > 0) begin
            rd = rv_q.pop_front();
            checks++; if (rd !== ref_read(64'h100)) begin errors++; $display("FAIL post_reset_data: got %h expected %h", rd, ref_read(64'h100)); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_skew();
        test_back_to_back();
        test_random();
        test_error_resp();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
